// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and FSM states for the UART receiver
// Purpose: constants and types imported by uart_rx_dev.
// Ports:   none (package).
package uart_pkg;

    // Register select values, taken from addr_in[3:2]
    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    // STATUS bit indices
    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_OVERRUN    = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_PARITY_ERR = 3;
    localparam int STAT_COUNT_LSB  = 8;

    // CTRL bit indices
    localparam int CTRL_RX_EN      = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_PARITY_ODD = 2;

    // RXDATA flag returned when the FIFO is empty
    localparam int RXDATA_EMPTY_BIT = 31;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: generic byte/word buffer; a push while full is dropped, a pop while empty is ignored.
// Ports:
//   clk       clock, rising edge
//   resetn    synchronous active-low reset (empties the FIFO)
//   push      write push_data when not full
//   push_data data to enqueue
//   pop       advance the head when not empty
//   head      current head entry (valid when !empty)
//   full      count == Depth
//   empty     count == 0
//   count     number of stored entries
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16,
    localparam int AW = $clog2(Depth),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_dev.sv
// rtl/uart_rx_dev.sv - UART receiver bus device with receive FIFO and level interrupt
// Purpose: deserialises 8-bit frames from rx_in into a FIFO; RXDATA/STATUS/CTRL/BAUD_DIV registers.
// Optional feature: define UART_RX_PARITY_EN for a parity bit (CTRL[2] parity_odd, STATUS[3] parity_err).
// Ports:
//   clk_in    clock, rising edge
//   reset_in  synchronous active-low reset
//   req_in    bus request; we_in selects write (1) or read (0)
//   addr_in   register select on [3:2]
//   wdata_in  write data
//   data_out  registered read data, valid the cycle after a read request
//   rx_in     asynchronous serial input, idle high
//   irq_out   registered level interrupt
module uart_rx_dev
    import uart_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int FifoDepth    = 16,
    parameter int DefaultDiv   = 868,
    localparam int CW = $clog2(FifoDepth) + 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    req_in,
    input  logic                    we_in,
    input  logic [AddressWidth-1:0] addr_in,
    input  logic [DataWidth-1:0]    wdata_in,
    output logic [DataWidth-1:0]    data_out,
    input  logic                    rx_in,
    output logic                    irq_out
);

    logic        rx_s1, rx_s2, rx_prev;
    rx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        push_q;
    logic [7:0]  push_byte;
    logic        frame_set;

    logic        rx_en, irq_en;
    logic [15:0] baud_div;
    logic        overrun, frame_err;

    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic        rd_access, wr_access, pop;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic        parity_flag;

`ifdef UART_RX_PARITY_EN
    logic parity_odd, parity_err, parity_set, par_bad;
    assign parity_flag = parity_err;
`else
    assign parity_flag = 1'b0;
`endif

    assign sel       = addr_in[3:2];
    assign rd_access = req_in & ~we_in;
    assign wr_access = req_in & we_in;
    assign pop       = rd_access & (sel == REG_RXDATA) & ~fifo_empty;

    // Bits outside the decoded window are intentionally ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr_in[AddressWidth-1:4], addr_in[1:0], wdata_in[DataWidth-1:16]};

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk_in),
        .resetn    (reset_in),
        .push      (push_q),
        .push_data (push_byte),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive FSM. Each sample point is where baud_cnt reaches zero; the
    // counter is reloaded from baud_div there, so BAUD_DIV changes land on
    // the next reload. push_q/frame_set are one-cycle registered pulses.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state     <= RX_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            push_q    <= 1'b0;
            push_byte <= '0;
            frame_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_set <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            push_q    <= 1'b0;
            frame_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_set <= 1'b0;
`endif
            if (!rx_en) begin
                state <= RX_IDLE;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_s2) begin
                            state    <= RX_START;
                            baud_cnt <= (baud_div >> 1) - 16'd1;
                        end
                    end
                    RX_START: begin
                        if (baud_cnt != 16'd0) begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end else if (rx_s2) begin
                            state <= RX_IDLE;
                        end else begin
                            state    <= RX_DATA;
                            bit_cnt  <= '0;
                            baud_cnt <= baud_div - 16'd1;
                        end
                    end
                    RX_DATA: begin
                        if (baud_cnt != 16'd0) begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end else begin
                            shift    <= {rx_s2, shift[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            baud_cnt <= baud_div - 16'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= RX_PARITY;
`else
                                state <= RX_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    RX_PARITY: begin
                        if (baud_cnt != 16'd0) begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end else begin
                            par_bad    <= ((^shift) ^ rx_s2) != parity_odd;
                            parity_set <= ((^shift) ^ rx_s2) != parity_odd;
                            baud_cnt   <= baud_div - 16'd1;
                            state      <= RX_STOP;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (baud_cnt != 16'd0) begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end else begin
                            state <= RX_IDLE;
                            if (rx_s2) begin
`ifdef UART_RX_PARITY_EN
                                push_q <= ~par_bad;
`else
                                push_q <= 1'b1;
`endif
                                push_byte <= shift;
                            end else begin
                                frame_set <= 1'b1;
                            end
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_RXDATA: begin
                if (fifo_empty) begin
                    rdata[RXDATA_EMPTY_BIT] = 1'b1;
                end else begin
                    rdata[7:0] = fifo_head;
                end
            end
            REG_STATUS: begin
                rdata[STAT_NOT_EMPTY]  = ~fifo_empty;
                rdata[STAT_OVERRUN]    = overrun;
                rdata[STAT_FRAME_ERR]  = frame_err;
                rdata[STAT_PARITY_ERR] = parity_flag;
                rdata[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
            end
            REG_CTRL: begin
                rdata[CTRL_RX_EN]  = rx_en;
                rdata[CTRL_IRQ_EN] = irq_en;
`ifdef UART_RX_PARITY_EN
                rdata[CTRL_PARITY_ODD] = parity_odd;
`endif
            end
            default: rdata[15:0] = baud_div;
        endcase
    end

    // Register file. Flag update is (old & ~clear) | set, so an FSM set in
    // the same cycle as a W1C clear wins.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            data_out  <= '0;
            irq_out   <= 1'b0;
            rx_en     <= 1'b0;
            irq_en    <= 1'b0;
            baud_div  <= 16'(DefaultDiv);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_odd <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (rd_access) begin
                data_out <= DataWidth'(rdata);
            end
            if (wr_access && sel == REG_CTRL) begin
                rx_en  <= wdata_in[CTRL_RX_EN];
                irq_en <= wdata_in[CTRL_IRQ_EN];
`ifdef UART_RX_PARITY_EN
                parity_odd <= wdata_in[CTRL_PARITY_ODD];
`endif
            end
            if (wr_access && sel == REG_BAUD) begin
                baud_div <= (wdata_in[15:0] < MIN_BAUD_DIV) ? MIN_BAUD_DIV : wdata_in[15:0];
            end
            overrun <= (overrun & ~(wr_access && sel == REG_STATUS && wdata_in[STAT_OVERRUN]))
                       | (push_q & fifo_full);
            frame_err <= (frame_err & ~(wr_access && sel == REG_STATUS && wdata_in[STAT_FRAME_ERR]))
                         | frame_set;
`ifdef UART_RX_PARITY_EN
            parity_err <= (parity_err & ~(wr_access && sel == REG_STATUS && wdata_in[STAT_PARITY_ERR]))
                          | parity_set;
`endif
            irq_out <= irq_en & (~fifo_empty | overrun | frame_err | parity_flag);
        end
    end

endmodule
